// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access size codes, FSM states, request bundle.
package dmem_pkg;

  typedef enum logic [2:0] {
    LS_B  = 3'd0,
    LS_H  = 3'd1,
    LS_W  = 3'd2,
    LS_BU = 3'd4,
    LS_HU = 3'd5
  } ls_funct3_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h0001_0000;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
  } dmem_req_t;

  // Stores only have byte/half/word codes; loads add the unsigned byte/half variants.
  function automatic logic ls_funct3_legal(input logic we, input logic [2:0] f);
    if (we) return (f == 3'b000) || (f == 3'b001) || (f == 3'b010);
    return (f == 3'b000) || (f == 3'b001) || (f == 3'b010) || (f == 3'b100) || (f == 3'b101);
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised backing RAM with per-byte write enables.
// Latency: write commits at the clock edge; read is combinational.
// Backpressure: none, always accepts.
module dmem_byte_ram #(
  parameter int ADDR_WIDTH = 17
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-3:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**(ADDR_WIDTH-2)];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Load/store responder in front of a byte-lane RAM; MISALIGN_TRAP_EN turns misaligned accesses into errors.
// Latency: rsp_valid pulses LATENCY cycles after the accept edge; errors take the same time.
// Backpressure: one request in flight, req_ready low from accept until after the response pulse.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          LATENCY    = 2,
  parameter int          ADDR_WIDTH = 17,
  parameter logic [31:0] BASE_ADDR  = DMEM_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_funct3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  dmem_state_e state;
  dmem_req_t   held;
  dmem_req_t   cur;
  logic [3:0]  cnt;
  logic        accept;
  logic        do_access;
  logic [31:0] off;
  logic        hit;
  logic        misal_err;
  logic        err;
  logic [1:0]  size;
  logic [1:0]  lane;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic [31:0] shifted;
  logic [31:0] ld_data;

  assign accept = req_valid && req_ready;

  // With LATENCY==1 the access happens on the accept edge itself, so it must see the live request.
  assign cur = (state == IDLE) ? {req_we, req_addr, req_wdata, req_funct3} : held;

  always_comb begin
    case (state)
      IDLE:    do_access = accept && (LATENCY == 1);
      WAIT:    do_access = (cnt == 4'd0);
      default: do_access = 1'b0;
    endcase
  end

  assign off  = cur.addr - BASE_ADDR;
  assign hit  = (cur.addr >= BASE_ADDR) && ((off >> ADDR_WIDTH) == 32'd0);
  assign size = cur.funct3[1:0];

`ifdef MISALIGN_TRAP_EN
  assign misal_err = ((size == 2'b01) && off[0]) || ((size == 2'b10) && (off[1:0] != 2'b00));
`else
  assign misal_err = 1'b0;
`endif

  assign err = !hit || !ls_funct3_legal(cur.we, cur.funct3) || misal_err;

  always_comb begin
    lane = off[1:0];
    if (size == 2'b01)      lane[0] = 1'b0;
    else if (size == 2'b10) lane = 2'b00;
  end

  always_comb begin
    ram_wdata = cur.wdata;
    ram_be    = 4'b1111;
    case (size)
      2'b00: begin
        ram_wdata = {4{cur.wdata[7:0]}};
        ram_be    = 4'b0001 << lane;
      end
      2'b01: begin
        ram_wdata = {2{cur.wdata[15:0]}};
        ram_be    = lane[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  assign ram_we = do_access && cur.we && !err && !rst;

  dmem_byte_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (ram_be),
    .addr  (off[ADDR_WIDTH-1:2]),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign shifted = ram_rdata >> {lane, 3'b000};

  always_comb begin
    case (ls_funct3_e'(cur.funct3))
      LS_B:    ld_data = {{24{shifted[7]}}, shifted[7:0]};
      LS_H:    ld_data = {{16{shifted[15]}}, shifted[15:0]};
      LS_W:    ld_data = shifted;
      LS_BU:   ld_data = {24'd0, shifted[7:0]};
      LS_HU:   ld_data = {16'd0, shifted[15:0]};
      default: ld_data = 32'd0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      held      <= '0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      if (do_access) begin
        rsp_valid <= 1'b1;
        rsp_err   <= err;
        rsp_rdata <= (err || cur.we) ? 32'd0 : ld_data;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            held      <= cur;
            req_ready <= 1'b0;
            if (LATENCY == 1) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: four responders (LATENCY 2, 4, 1, 7) on a 64-byte RAM sharing request data lines.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] vld;
  logic we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [2:0] f3;
  logic [3:0] rdy;
  logic [3:0] rvld;
  logic [3:0] err;
  logic [3:0][31:0] rdata;

  int total = 0;
  int bad = 0;
  int lats [4] = '{2, 4, 1, 7};

  always #5 clk = ~clk;

  dmem_responder #(.LATENCY(2), .ADDR_WIDTH(6)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(vld[0]), .req_ready(rdy[0]), .req_we(we), .req_addr(addr),
    .req_wdata(wdata), .req_funct3(f3), .rsp_valid(rvld[0]), .rsp_rdata(rdata[0]), .rsp_err(err[0]));
  dmem_responder #(.LATENCY(4), .ADDR_WIDTH(6)) u_l4 (
    .clk(clk), .rst(rst), .req_valid(vld[1]), .req_ready(rdy[1]), .req_we(we), .req_addr(addr),
    .req_wdata(wdata), .req_funct3(f3), .rsp_valid(rvld[1]), .rsp_rdata(rdata[1]), .rsp_err(err[1]));
  dmem_responder #(.LATENCY(1), .ADDR_WIDTH(6)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(vld[2]), .req_ready(rdy[2]), .req_we(we), .req_addr(addr),
    .req_wdata(wdata), .req_funct3(f3), .rsp_valid(rvld[2]), .rsp_rdata(rdata[2]), .rsp_err(err[2]));
  dmem_responder #(.LATENCY(7), .ADDR_WIDTH(6)) u_l7 (
    .clk(clk), .rst(rst), .req_valid(vld[3]), .req_ready(rdy[3]), .req_we(we), .req_addr(addr),
    .req_wdata(wdata), .req_funct3(f3), .rsp_valid(rvld[3]), .rsp_rdata(rdata[3]), .rsp_err(err[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One request on instance k; returns the response and checks its latency.
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [2:0] f, output logic [31:0] rd, output logic e);
    int lat;
    @(posedge clk); #1;
    we = w; addr = a; wdata = d; f3 = f; vld[k] = 1'b1;
    @(posedge clk); #1;
    vld[k] = 1'b0;
    lat = 0; rd = '0; e = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (rvld[k]) begin
        lat = i; rd = rdata[k]; e = err[k];
        break;
      end
    end
    check($sformatf("lat%0d", k), lat, lats[k]);
  endtask

  task automatic sweep(input int k);
    int acc, rsp, first, second, l;
    l = lats[k];
    acc = 0; rsp = 0; first = -1; second = -1;
    @(posedge clk); #1;
    we = 1'b0; addr = 32'h0001_0000; f3 = 3'b010; vld[k] = 1'b1;
    for (int c = 0; c < 4 * (l + 1); c++) begin
      @(negedge clk);
      if (rvld[k]) rsp++;
      if (rdy[k]) begin
        acc++;
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
    end
    @(posedge clk); #1;
    vld[k] = 1'b0;
    repeat (2) @(posedge clk);
    check($sformatf("sweep_acc%0d", k), acc, 4);
    check($sformatf("sweep_rsp%0d", k), rsp, 4);
    check($sformatf("sweep_gap%0d", k), second - first, l + 1);
  endtask

  initial begin
    logic [31:0] rd;
    logic e;
    int seen;
    vld = '0; we = 1'b0; addr = '0; wdata = '0; f3 = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", rdy[0], 1);
    check("rst_rvld", rvld[0], 0);
    check("rst_rdata", rdata[0], 0);
    check("rst_err", err[0], 0);

    // Fill RAM with a pattern, then a missed store must leave it untouched.
    txn(0, 1'b1, 32'h0001_0000, 32'h5A5A_0000, 3'b010, rd, e);
    check("sw_rdata", rd, 0);
    check("sw_err", e, 0);
    @(negedge clk);
    check("ready_back", rdy[0], 1);
    for (int i = 1; i < 16; i++) txn(0, 1'b1, 32'h0001_0000 + 4 * i, 32'h5A5A_0000 + i, 3'b010, rd, e);
    txn(0, 1'b1, 32'h0000_FFFC, 32'h0, 3'b010, rd, e);
    check("sw_miss_err", e, 1);
    for (int i = 0; i < 16; i++) begin
      txn(0, 1'b0, 32'h0001_0000 + 4 * i, 32'h0, 3'b010, rd, e);
      check($sformatf("ram%0d", i), rd, 32'h5A5A_0000 + i);
    end

    txn(0, 1'b1, 32'h0001_0000, 32'h8899_AABB, 3'b010, rd, e);
    txn(0, 1'b0, 32'h0001_0001, 32'h0, 3'b000, rd, e);
    check("lb", rd, 32'hFFFF_FFAA);
    txn(0, 1'b0, 32'h0001_0001, 32'h0, 3'b100, rd, e);
    check("lbu", rd, 32'h0000_00AA);
    txn(0, 1'b1, 32'h0001_0003, 32'h0000_0011, 3'b000, rd, e);
    txn(0, 1'b0, 32'h0001_0000, 32'h0, 3'b010, rd, e);
    check("sb_lw", rd, 32'h1199_AABB);
    txn(0, 1'b1, 32'h0001_0002, 32'h0000_F00D, 3'b001, rd, e);
    txn(0, 1'b0, 32'h0001_0000, 32'h0, 3'b010, rd, e);
    check("sh_lw", rd, 32'hF00D_AABB);
    txn(0, 1'b0, 32'h0001_0002, 32'h0, 3'b001, rd, e);
    check("lh", rd, 32'hFFFF_F00D);
    txn(0, 1'b0, 32'h0001_0002, 32'h0, 3'b101, rd, e);
    check("lhu", rd, 32'h0000_F00D);
    check("lhu_err", e, 0);

    txn(0, 1'b0, 32'h0000_FFFC, 32'h0, 3'b010, rd, e);
    check("low_err", e, 1);
    check("low_rdata", rd, 0);
    txn(0, 1'b0, 32'h0001_0040, 32'h0, 3'b010, rd, e);
    check("high_err", e, 1);
    txn(0, 1'b0, 32'h0001_0000, 32'h0, 3'b011, rd, e);
    check("f3_err", e, 1);
    check("f3_rdata", rd, 0);

`ifdef MISALIGN_TRAP_EN
    txn(0, 1'b0, 32'h0001_0002, 32'h0, 3'b010, rd, e);
    check("mis_lw_err", e, 1);
    check("mis_lw_rdata", rd, 0);
    txn(0, 1'b1, 32'h0001_0001, 32'h0000_BEEF, 3'b001, rd, e);
    check("mis_sh_err", e, 1);
    txn(0, 1'b0, 32'h0001_0000, 32'h0, 3'b010, rd, e);
    check("mis_sh_nowr", rd, 32'hF00D_AABB);
`else
    txn(0, 1'b0, 32'h0001_0002, 32'h0, 3'b010, rd, e);
    check("mis_lw_err", e, 0);
    check("mis_lw_rdata", rd, 32'hF00D_AABB);
`endif

    // Reset in the middle of a pending store on the LATENCY=4 instance.
    txn(1, 1'b1, 32'h0001_0010, 32'h1234_5678, 3'b010, rd, e);
    @(posedge clk); #1;
    we = 1'b1; addr = 32'h0001_0010; wdata = 32'hDEAD_BEEF; f3 = 3'b010; vld[1] = 1'b1;
    @(posedge clk); #1;
    vld[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rvld[1]) seen++;
    end
    check("rst_novld", seen, 0);
    check("rst_ready4", rdy[1], 1);
    txn(1, 1'b0, 32'h0001_0010, 32'h0, 3'b010, rd, e);
    check("rst_nowr", rd, 32'h1234_5678);

    txn(2, 1'b1, 32'h0001_0004, 32'hCAFE_F00D, 3'b010, rd, e);
    txn(2, 1'b0, 32'h0001_0004, 32'h0, 3'b010, rd, e);
    check("l1_lw", rd, 32'hCAFE_F00D);
    txn(3, 1'b1, 32'h0001_0008, 32'h0BAD_CAFE, 3'b010, rd, e);
    txn(3, 1'b0, 32'h0001_0008, 32'h0, 3'b010, rd, e);
    check("l7_lw", rd, 32'h0BAD_CAFE);

    sweep(2);
    sweep(0);
    sweep(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
